// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV32/RV64 immediate generator for the ID stage.
//
// The opcode selects the immediate format (I/S/B/U/J/CSR zimm). The decoded
// immediate, format code and illegal flag go through a two-entry skid buffer.
// The main register drives the outputs and the skid register absorbs one extra
// beat. This means ready_o is a plain register and has no combinational path
// from ready_i.
//
// Ports
//   clk_i      in   1     clock; all state changes on the rising edge
//   rst_i      in   1     asynchronous reset, active-low
//   flush_i    in   1     synchronous flush of all buffered beats
//   valid_i    in   1     inst_i valid
//   ready_o    out  1     a beat can be accepted (skid entry empty)
//   inst_i     in   32    instruction word
//   valid_o    out  1     imm_o / fmt_o / illegal_o valid
//   ready_i    in   1     downstream accepts the beat
//   imm_o      out  XLEN  generated immediate (0 when !valid_o)
//   fmt_o      out  3     0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (csr zimm)
//   illegal_o  out  1     unknown opcode, or CSR-imm with EN_CSR = 0
module imm_gen_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter bit          EN_CSR = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [31:0]     inst_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic            illegal_o
);

  localparam logic [2:0] FmtNone = 3'd0;
  localparam logic [2:0] FmtI    = 3'd1;
  localparam logic [2:0] FmtS    = 3'd2;
  localparam logic [2:0] FmtB    = 3'd3;
  localparam logic [2:0] FmtU    = 3'd4;
  localparam logic [2:0] FmtJ    = 3'd5;
  localparam logic [2:0] FmtZ    = 3'd6;

  // Packed beat: {imm, fmt, illegal}.
  localparam int unsigned DataW = XLEN + 4;

  logic [31:0]      imm32;
  logic [XLEN-1:0]  dec_imm;
  logic [2:0]       dec_fmt;
  logic             dec_ill;
  logic [DataW-1:0] dec_data;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  always_comb begin
    imm32   = '0;
    dec_fmt = FmtNone;
    dec_ill = 1'b0;
    case (inst_i[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: begin
        imm32   = {{20{inst_i[31]}}, inst_i[31:20]};
        dec_fmt = FmtI;
      end
      7'b0100011: begin
        imm32   = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
        dec_fmt = FmtS;
      end
      7'b1100011: begin
        imm32   = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
        dec_fmt = FmtB;
      end
      7'b0110111, 7'b0010111: begin
        imm32   = {inst_i[31:12], 12'b0};
        dec_fmt = FmtU;
      end
      7'b1101111: begin
        imm32   = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
        dec_fmt = FmtJ;
      end
      7'b1110011: begin
        // funct3[2] selects the immediate CSR forms; others carry no immediate.
        if (inst_i[14]) begin
          if (EN_CSR) begin
            imm32   = {27'b0, inst_i[19:15]};
            dec_fmt = FmtZ;
          end else begin
            dec_ill = 1'b1;
          end
        end
      end
      7'b0110011, 7'b0001111: begin
        dec_fmt = FmtNone;
      end
      default: begin
        dec_ill = 1'b1;
      end
    endcase
  end

  // The 32-bit immediate is already sign-correct. Zimm has bit 31 clear, so
  // sign extension leaves it zero-extended.
  if (XLEN > 32) begin : g_sext
    assign dec_imm = {{(XLEN - 32){imm32[31]}}, imm32};
  end else begin : g_nosext
    assign dec_imm = imm32;
  end

  assign dec_data = {dec_imm, dec_fmt, dec_ill};

  // ---------------------------------------------------------------------------
  // Skid buffer
  // ---------------------------------------------------------------------------
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [DataW-1:0] main_q;
  logic [DataW-1:0] skid_q;
  logic             in_fire, out_fire;
  logic             load_main_new, load_main_skid, load_skid;

  assign ready_o  = ~skid_valid_q;
  assign in_fire  = valid_i & ready_o;
  assign out_fire = main_valid_q & ready_i;

  always_comb begin
    main_valid_d   = main_valid_q;
    skid_valid_d   = skid_valid_q;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // ready_o is low here, so only the drain side can move.
      if (out_fire) begin
        load_main_skid = 1'b1;
        skid_valid_d   = 1'b0;
      end
    end else if (in_fire) begin
      if (!main_valid_q || out_fire) begin
        load_main_new = 1'b1;
        main_valid_d  = 1'b1;
      end else begin
        load_skid    = 1'b1;
        skid_valid_d = 1'b1;
      end
    end else if (out_fire) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_new) begin
        main_q <= dec_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= dec_data;
      end
    end
  end

  // Outputs are masked so a stale beat never shows while invalid.
  assign valid_o = main_valid_q;
  always_comb begin
    {imm_o, fmt_o, illegal_o} = main_valid_q ? main_q : '0;
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        flush_i, valid_i, ready_i;
  logic [31:0] inst_i;

  // Three instances share all inputs: RV32, RV64, and RV32 with CSR-imm disabled.
  logic        rdy_a, vld_a, ill_a;
  logic [31:0] imm_a;
  logic [2:0]  fmt_a;
  logic        rdy_b, vld_b, ill_b;
  logic [63:0] imm_b;
  logic [2:0]  fmt_b;
  logic        rdy_c, vld_c, ill_c;
  logic [31:0] imm_c;
  logic [2:0]  fmt_c;

  imm_gen_pipe #(.XLEN(32), .EN_CSR(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rdy_a),
    .inst_i(inst_i), .valid_o(vld_a), .ready_i(ready_i), .imm_o(imm_a), .fmt_o(fmt_a),
    .illegal_o(ill_a));

  imm_gen_pipe #(.XLEN(64), .EN_CSR(1'b1)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rdy_b),
    .inst_i(inst_i), .valid_o(vld_b), .ready_i(ready_i), .imm_o(imm_b), .fmt_o(fmt_b),
    .illegal_o(ill_b));

  imm_gen_pipe #(.XLEN(32), .EN_CSR(1'b0)) dut_c (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rdy_c),
    .inst_i(inst_i), .valid_o(vld_c), .ready_i(ready_i), .imm_o(imm_c), .fmt_o(fmt_c),
    .illegal_o(ill_c));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];  // reference: in-order beats held by the block (at most 2)

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference decode from the instruction-set rules, using signed arithmetic.
  task automatic model(input logic [31:0] inst, input bit is64, input bit en_csr,
                       output logic [63:0] imm, output logic [2:0] fmt, output logic ill);
    longint s, r;
    s   = longint'($signed(inst));
    r   = 0;
    fmt = 3'd0;
    ill = 1'b0;
    case (inst[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: begin r = s >>> 20; fmt = 3'd1; end
      7'b0100011: begin r = ((s >>> 25) << 5) | longint'(inst[11:7]); fmt = 3'd2; end
      7'b1100011: begin
        r = ((s >>> 31) << 12) | (longint'(inst[7]) << 11) | (longint'(inst[30:25]) << 5)
            | (longint'(inst[11:8]) << 1);
        fmt = 3'd3;
      end
      7'b0110111, 7'b0010111: begin r = s & ~longint'(4095); fmt = 3'd4; end
      7'b1101111: begin
        r = ((s >>> 31) << 20) | (longint'(inst[19:12]) << 12) | (longint'(inst[20]) << 11)
            | (longint'(inst[30:21]) << 1);
        fmt = 3'd5;
      end
      7'b1110011: begin
        if (inst[14]) begin
          if (en_csr) begin r = longint'(inst[19:15]); fmt = 3'd6; end
          else ill = 1'b1;
        end
      end
      7'b0110011, 7'b0001111: ;
      default: ill = 1'b1;
    endcase
    imm = is64 ? 64'(r) : {32'b0, r[31:0]};
  endtask

  task automatic check_dut(input string tag, input bit is64, input bit en, input logic v,
                           input logic r, input logic [63:0] imm, input logic [2:0] fmt,
                           input logic ill);
    logic [63:0] e_imm;
    logic [2:0]  e_fmt;
    logic        e_ill;
    chk({tag, "_valid"}, 64'(v), 64'(q.size() > 0));
    chk({tag, "_ready"}, 64'(r), 64'(q.size() < 2));
    if (q.size() > 0) model(q[0], is64, en, e_imm, e_fmt, e_ill);
    else begin e_imm = '0; e_fmt = '0; e_ill = 1'b0; end
    chk({tag, "_imm"}, imm, e_imm);
    chk({tag, "_fmt"}, 64'(fmt), 64'(e_fmt));
    chk({tag, "_ill"}, 64'(ill), 64'(e_ill));
  endtask

  task automatic compare_all();
    check_dut("x32", 1'b0, 1'b1, vld_a, rdy_a, 64'(imm_a), fmt_a, ill_a);
    check_dut("x64", 1'b1, 1'b1, vld_b, rdy_b, imm_b, fmt_b, ill_b);
    check_dut("nocsr", 1'b0, 1'b0, vld_c, rdy_c, 64'(imm_c), fmt_c, ill_c);
  endtask

  // Drive one cycle just after a falling edge, advance the reference FIFO, and
  // check at the next falling edge.
  task automatic cycle(input bit v, input logic [31:0] inst, input bit rdy, input bit fl);
    bit acc, pop;
    valid_i = v;
    inst_i  = inst;
    ready_i = rdy;
    flush_i = fl;
    acc = v && (q.size() < 2);
    pop = (q.size() > 0) && rdy;
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(inst);
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  logic [6:0] ops [11] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73,
                           7'h33, 7'h0F};

  initial begin
    logic [63:0] m_imm;
    logic [2:0]  m_fmt;
    logic        m_ill;
    logic [31:0] rnd;
    logic [6:0]  op;

    rst_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; inst_i = '0;

    // Pin the reference model with hand-computed values.
    model(32'hFFF00093, 1'b0, 1'b1, m_imm, m_fmt, m_ill);
    chk("pin_addi", m_imm, 64'hFFFFFFFF);
    model(32'hFE20AE23, 1'b0, 1'b1, m_imm, m_fmt, m_ill);
    chk("pin_sw", m_imm, 64'hFFFFFFFC);
    model(32'hFE000CE3, 1'b0, 1'b1, m_imm, m_fmt, m_ill);
    chk("pin_beq", m_imm, 64'hFFFFFFF8);
    model(32'h800000B7, 1'b1, 1'b1, m_imm, m_fmt, m_ill);
    chk("pin_lui64", m_imm, 64'hFFFFFFFF80000000);
    model(32'h3400D073, 1'b0, 1'b1, m_imm, m_fmt, m_ill);
    chk("pin_csr", {m_imm[60:0], m_fmt}, 64'h0E);

    // Reset state.
    repeat (3) @(negedge clk);
    compare_all();
    chk("rst_ready", 64'(rdy_a), 64'd1);
    rst_i = 1'b1;

    // Literal expectations through the pipe.
    cycle(1'b1, 32'hFFF00093, 1'b1, 1'b0);
    chk("t1_imm", 64'(imm_a), 64'hFFFFFFFF);
    chk("t1_fmt", 64'(fmt_a), 64'd1);
    cycle(1'b1, 32'hFE20AE23, 1'b1, 1'b0);
    chk("t2_sw", {28'(imm_a), fmt_a}, {28'hFFFFFFC, 3'd2});
    cycle(1'b1, 32'hFE000CE3, 1'b1, 1'b0);
    chk("t2_beq", {28'(imm_a), fmt_a}, {28'hFFFFFF8, 3'd3});
    cycle(1'b1, 32'h123450B7, 1'b1, 1'b0);
    chk("t3_lui", imm_b, 64'h0000000012345000);
    cycle(1'b1, 32'h800000B7, 1'b1, 1'b0);
    chk("t3_lui_neg", imm_b, 64'hFFFFFFFF80000000);
    chk("t3_fmt", 64'(fmt_b), 64'd4);
    cycle(1'b1, 32'h0000007F, 1'b1, 1'b0);
    chk("t6_illegal", {63'(imm_a), ill_a}, 64'd1);
    cycle(1'b1, 32'h3400D073, 1'b1, 1'b0);
    chk("t6_zimm", {61'(imm_a), fmt_a}, {61'd1, 3'd6});
    chk("t6_nocsr_ill", 64'(ill_c), 64'd1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Back-pressure: A, B, C with the sink stalled, then drain in order.
    cycle(1'b1, 32'hFFF00093, 1'b0, 1'b0);
    cycle(1'b1, 32'h00500113, 1'b0, 1'b0);
    cycle(1'b1, 32'h00A00193, 1'b0, 1'b0);
    chk("t4_ready_low", 64'(rdy_a), 64'd0);
    chk("t4_hold_a", 64'(imm_a), 64'hFFFFFFFF);
    cycle(1'b1, 32'h00A00193, 1'b1, 1'b0);
    chk("t4_b", 64'(imm_a), 64'd5);
    cycle(1'b1, 32'h00A00193, 1'b1, 1'b0);
    chk("t4_c", 64'(imm_a), 64'd10);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t4_empty", 64'(vld_a), 64'd0);

    // Flush with two beats buffered and a beat presented.
    cycle(1'b1, 32'hFFF00093, 1'b0, 1'b0);
    cycle(1'b1, 32'h00500113, 1'b0, 1'b0);
    cycle(1'b1, 32'h00A00193, 1'b0, 1'b1);
    chk("t5_flush", {62'(vld_a), rdy_a}, 64'd1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t5_dropped", 64'(vld_a), 64'd0);

    // Asynchronous reset in the middle of a stall.
    cycle(1'b1, 32'hFFF00093, 1'b0, 1'b0);
    cycle(1'b1, 32'h00500113, 1'b0, 1'b0);
    valid_i = 1'b0;
    #2 rst_i = 1'b0;
    #1;
    chk("t6_rst_async", {imm_b, vld_b}, 65'd0);
    chk("t6_rst_ready", 64'(rdy_a), 64'd1);
    q.delete();
    @(negedge clk);
    compare_all();
    rst_i = 1'b1;

    // Randomised traffic against the reference FIFO.
    for (int i = 0; i < 3000; i++) begin
      rnd = $urandom;
      op  = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 10)] : 7'($urandom);
      cycle(($urandom_range(0, 3) != 0), {rnd[31:7], op}, ($urandom_range(0, 4) < 3),
            ($urandom_range(0, 39) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
